soc_ram_arbiter: RTL and testbench

Two-master round-robin arbiter for port s1 of the 8192×32 dual-port on-chip SoC RAM. It lets a Nios data master (m0) and a DMA master (m1) share the single s1 port through Avalon-MM slave interfaces with waitrequest and readdatavalid. It issues at most one RAM access per cycle and returns read data one cycle after issue. Port s2 stays dedicated to the instruction master and is outside this block.

---
 rtl/soc_ram_arb_pkg.sv | 15 +
 rtl/soc_ram_arb_pick.sv | 45 ++++
 rtl/soc_ram_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_soc_ram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_ram_arb_pkg.sv
// Shared types and defaults for the SoC RAM port-s1 arbiter.
// Contents: grant_t (which master owns the port), default address/data widths
// and the default lock timeout used when SOC_RAM_ARB_LOCK_EN is defined.
package soc_ram_arb_pkg;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } grant_t;

  localparam int unsigned AddrWDefault   = 13;
  localparam int unsigned DataWDefault   = 32;
  localparam int unsigned LockMaxDefault = 64;

endpackage

// File: rtl/soc_ram_arb_pick.sv
// Combinational 2-way round-robin picker.
// Ports:
//   req_i         request per master (bit x = master x)
//   last_grant_i  master granted most recently; the other one wins a tie
//   force_valid_i restrict the choice to force_id_i (lock ownership)
//   force_id_i    only master allowed to win while force_valid_i is high
//   valid_o       a winner exists this cycle
//   winner_o      winning master; GNT_M0 when there is no winner
module soc_ram_arb_pick
  import soc_ram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  grant_t     last_grant_i,
  input  logic       force_valid_i,
  input  grant_t     force_id_i,
  output logic       valid_o,
  output grant_t     winner_o
);

  always_comb begin
    valid_o  = 1'b0;
    winner_o = GNT_M0;
    if (force_valid_i) begin
      valid_o  = (force_id_i == GNT_M1) ? req_i[1] : req_i[0];
      winner_o = valid_o ? force_id_i : GNT_M0;
    end else begin
      case (req_i)
        2'b01: begin
          valid_o  = 1'b1;
          winner_o = GNT_M0;
        end
        2'b10: begin
          valid_o  = 1'b1;
          winner_o = GNT_M1;
        end
        2'b11: begin
          valid_o  = 1'b1;
          winner_o = (last_grant_i == GNT_M0) ? GNT_M1 : GNT_M0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/soc_ram_arbiter.sv
// Two-master round-robin arbiter for port s1 of the on-chip SoC RAM.
// m0 (Nios data) and m1 (DMA) are Avalon-MM slaves with waitrequest and
// readdatavalid; at most one RAM access is issued per cycle and read data
// returns one cycle after issue.
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   mX_address/byteenable/read/write/writedata  master X request
//   mX_waitrequest           transfer not accepted this cycle
//   mX_readdata/readdatavalid read response for master X
//   ram_*                    RAM port s1 (ram_readdata valid 1 cycle after issue)
//   mX_lock, lock_err        only with SOC_RAM_ARB_LOCK_EN defined: hold the
//                            grant after this transfer / sticky forced release
module soc_ram_arbiter
  import soc_ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault,
  localparam int unsigned BE_W  = DATA_W / 8
`ifdef SOC_RAM_ARB_LOCK_EN
  , parameter int unsigned LOCK_MAX = LockMaxDefault
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
`ifdef SOC_RAM_ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
  output logic              lock_err,
`endif
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  logic [1:0] req;
  logic       pick_valid, grant, win_m1, rd_accept;
  grant_t     winner;
  grant_t     last_grant_q, last_grant_d;
  logic       rd_tag_valid_q;
  grant_t     rd_tag_id_q;
  logic       force_valid, lock_release;
  grant_t     force_id;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  soc_ram_arb_pick u_pick (
    .req_i         (req),
    .last_grant_i  (last_grant_q),
    .force_valid_i (force_valid),
    .force_id_i    (force_id),
    .valid_o       (pick_valid),
    .winner_o      (winner)
  );

  // Nothing is granted while reset is held.
  assign grant  = pick_valid & reset_n;
  assign win_m1 = (winner == GNT_M1);

  assign m0_waitrequest = ~reset_n | (req[0] & ~(grant & ~win_m1));
  assign m1_waitrequest = ~reset_n | (req[1] & ~(grant & win_m1));

  // With no winner, winner is GNT_M0 so the mux rests on m0.
  assign ram_address    = win_m1 ? m1_address    : m0_address;
  assign ram_byteenable = win_m1 ? m1_byteenable : m0_byteenable;
  assign ram_writedata  = win_m1 ? m1_writedata  : m0_writedata;
  assign ram_write      = grant & (win_m1 ? m1_write : m0_write);
  assign ram_chipselect = grant;
  assign ram_clken      = reset_n;

  // read+write together counts as a write, so it gets no read tag
  assign rd_accept = grant & ~ram_write;

  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  // Gating with reset_n drops a response whose read was accepted just before reset.
  assign m0_readdatavalid = reset_n & rd_tag_valid_q & (rd_tag_id_q == GNT_M0);
  assign m1_readdatavalid = reset_n & rd_tag_valid_q & (rd_tag_id_q == GNT_M1);

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant) begin
      last_grant_d = winner;
    end
    // After a forced release the non-owner gets the next tie.
    if (lock_release) begin
      last_grant_d = force_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q   <= GNT_M1;
      rd_tag_valid_q <= 1'b0;
      rd_tag_id_q    <= GNT_M0;
    end else begin
      last_grant_q   <= last_grant_d;
      rd_tag_valid_q <= rd_accept;
      if (rd_accept) begin
        rd_tag_id_q <= winner;
      end
    end
  end

`ifdef SOC_RAM_ARB_LOCK_EN
  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

  logic            locked_q, locked_d;
  grant_t          lock_owner_q, lock_owner_d;
  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
  logic            lock_err_q, lock_err_d;
  logic            sel_lock;

  assign force_valid = locked_q;
  assign force_id    = lock_owner_q;
  assign sel_lock    = win_m1 ? m1_lock : m0_lock;
  assign lock_err    = lock_err_q;

  always_comb begin
    locked_d     = locked_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    lock_err_d   = lock_err_q;
    lock_release = 1'b0;
    if (grant && sel_lock) begin
      locked_d     = 1'b1;
      lock_owner_d = winner;
      lock_cnt_d   = '0;
    end else if (locked_q) begin
      if (grant) begin
        // Only the owner can win while locked: this is its unlocking transfer.
        locked_d   = 1'b0;
        lock_cnt_d = '0;
      end else if (lock_cnt_q == CntW'(LOCK_MAX - 1)) begin
        locked_d     = 1'b0;
        lock_cnt_d   = '0;
        lock_err_d   = 1'b1;
        lock_release = 1'b1;
      end else begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      locked_q     <= 1'b0;
      lock_owner_q <= GNT_M0;
      lock_cnt_q   <= '0;
      lock_err_q   <= 1'b0;
    end else begin
      locked_q     <= locked_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      lock_err_q   <= lock_err_d;
    end
  end
`else
  assign force_valid  = 1'b0;
  assign force_id     = GNT_M0;
  assign lock_release = 1'b0;
`endif

endmodule

// File: tb/tb_soc_ram_arbiter.sv
// Self-checking bench for soc_ram_arbiter with a behavioural 1-cycle RAM on s1.
// Lock sequences are compiled only with SOC_RAM_ARB_LOCK_EN defined.
module tb_soc_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [12:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;
`ifdef SOC_RAM_ARB_LOCK_EN
  logic        m0_lock, m1_lock, lock_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  soc_ram_arbiter #(
`ifdef SOC_RAM_ARB_LOCK_EN
    .LOCK_MAX (4),
`endif
    .ADDR_W (13),
    .DATA_W (32)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
`ifdef SOC_RAM_ARB_LOCK_EN
    .m0_lock          (m0_lock),
    .m1_lock          (m1_lock),
    .lock_err         (lock_err),
`endif
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_writedata    (ram_writedata),
    .ram_clken        (ram_clken),
    .ram_readdata     (ram_readdata)
  );

  // Behavioural s1 RAM; preloaded while reset is held.
  logic [31:0] mem [0:8191];
  always @(posedge clk) begin
    if (!reset_n) begin
      mem[13'h0010] <= 32'hDEADBEEF;
      mem[13'h0020] <= 32'h12345678;
      mem[13'h0030] <= 32'h00000000;
      mem[13'h1FFF] <= 32'hCAFE0000;
    end else if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
        end
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  typedef struct {
    logic [1:0]  rw0;   // {read, write}
    logic [12:0] a0;
    logic [31:0] wd0;
    logic [3:0]  be0;
    logic [1:0]  rw1;
    logic [12:0] a1;
    logic [31:0] wd1;
    logic [3:0]  be1;
    logic [3:0]  ex;    // {m0_waitrequest, m1_waitrequest, ram_chipselect, ram_write}
    logic [12:0] ea;    // ram_address, checked when chipselect expected
    logic [1:0]  erv;   // {m0_readdatavalid, m1_readdatavalid}
    logic [31:0] erd;   // readdata, checked when a valid is expected
  } vec_t;

  function automatic vec_t mk(input logic [1:0] rw0, input logic [12:0] a0,
                              input logic [31:0] wd0, input logic [3:0] be0,
                              input logic [1:0] rw1, input logic [12:0] a1,
                              input logic [31:0] wd1, input logic [3:0] be1,
                              input logic [3:0] ex, input logic [12:0] ea,
                              input logic [1:0] erv, input logic [31:0] erd);
    vec_t v;
    v.rw0 = rw0; v.a0 = a0; v.wd0 = wd0; v.be0 = be0;
    v.rw1 = rw1; v.a1 = a1; v.wd1 = wd1; v.be1 = be1;
    v.ex = ex; v.ea = ea; v.erv = erv; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rw0, input logic [12:0] a0, input logic [31:0] wd0,
                       input logic [3:0] be0, input logic [1:0] rw1, input logic [12:0] a1,
                       input logic [31:0] wd1, input logic [3:0] be1);
    {m0_read, m0_write} = rw0;
    m0_address = a0; m0_writedata = wd0; m0_byteenable = be0;
    {m1_read, m1_write} = rw1;
    m1_address = a1; m1_writedata = wd1; m1_byteenable = be1;
  endtask

  task automatic idle();
    drive(2'b00, 13'h0, 32'h0, 4'h0, 2'b00, 13'h0, 32'h0, 4'h0);
  endtask

  // Advance to the next cycle's drive point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    step();
    step();
    reset_n = 1'b1;
  endtask

  vec_t vecs[$];

  initial begin
    // cycles 0-6: continuous contention; 7-8: lone read; 9-11: byte write then read;
    // 12-15: read/write same address back-to-back; 16-19: read+write treated as write;
    // 20-21: contention of a read against a write.
    vecs.push_back(mk(2'b10, 13'h0010, 0, 4'hF, 2'b10, 13'h0020, 0, 4'hF, 4'b0110, 13'h0010, 2'b00, 0));
    vecs.push_back(mk(2'b10, 13'h0010, 0, 4'hF, 2'b10, 13'h0020, 0, 4'hF, 4'b1010, 13'h0020, 2'b10, 32'hDEADBEEF));
    vecs.push_back(mk(2'b10, 13'h0010, 0, 4'hF, 2'b10, 13'h0020, 0, 4'hF, 4'b0110, 13'h0010, 2'b01, 32'h12345678));
    vecs.push_back(mk(2'b10, 13'h0010, 0, 4'hF, 2'b10, 13'h0020, 0, 4'hF, 4'b1010, 13'h0020, 2'b10, 32'hDEADBEEF));
    vecs.push_back(mk(2'b10, 13'h0010, 0, 4'hF, 2'b10, 13'h0020, 0, 4'hF, 4'b0110, 13'h0010, 2'b01, 32'h12345678));
    vecs.push_back(mk(2'b10, 13'h0010, 0, 4'hF, 2'b10, 13'h0020, 0, 4'hF, 4'b1010, 13'h0020, 2'b10, 32'hDEADBEEF));
    vecs.push_back(mk(2'b00, 13'h0000, 0, 4'h0, 2'b00, 13'h0000, 0, 4'h0, 4'b0000, 13'h0000, 2'b01, 32'h12345678));
    vecs.push_back(mk(2'b10, 13'h0010, 0, 4'hF, 2'b00, 13'h0000, 0, 4'h0, 4'b0010, 13'h0010, 2'b00, 0));
    vecs.push_back(mk(2'b00, 13'h0000, 0, 4'h0, 2'b00, 13'h0000, 0, 4'h0, 4'b0000, 13'h0000, 2'b10, 32'hDEADBEEF));
    vecs.push_back(mk(2'b00, 13'h0000, 0, 4'h0, 2'b01, 13'h1FFF, 32'hA5A5A5A5, 4'b0011, 4'b0011, 13'h1FFF, 2'b00, 0));
    vecs.push_back(mk(2'b10, 13'h1FFF, 0, 4'hF, 2'b00, 13'h0000, 0, 4'h0, 4'b0010, 13'h1FFF, 2'b00, 0));
    vecs.push_back(mk(2'b00, 13'h0000, 0, 4'h0, 2'b00, 13'h0000, 0, 4'h0, 4'b0000, 13'h0000, 2'b10, 32'hCAFEA5A5));
    vecs.push_back(mk(2'b10, 13'h1FFF, 0, 4'hF, 2'b00, 13'h0000, 0, 4'h0, 4'b0010, 13'h1FFF, 2'b00, 0));
    vecs.push_back(mk(2'b00, 13'h0000, 0, 4'h0, 2'b01, 13'h1FFF, 32'h11111111, 4'hF, 4'b0011, 13'h1FFF, 2'b10, 32'hCAFEA5A5));
    vecs.push_back(mk(2'b10, 13'h1FFF, 0, 4'hF, 2'b00, 13'h0000, 0, 4'h0, 4'b0010, 13'h1FFF, 2'b00, 0));
    vecs.push_back(mk(2'b00, 13'h0000, 0, 4'h0, 2'b00, 13'h0000, 0, 4'h0, 4'b0000, 13'h0000, 2'b10, 32'h11111111));
    vecs.push_back(mk(2'b11, 13'h0030, 32'h0BADF00D, 4'hF, 2'b00, 13'h0000, 0, 4'h0, 4'b0011, 13'h0030, 2'b00, 0));
    vecs.push_back(mk(2'b00, 13'h0000, 0, 4'h0, 2'b00, 13'h0000, 0, 4'h0, 4'b0000, 13'h0000, 2'b00, 0));
    vecs.push_back(mk(2'b00, 13'h0000, 0, 4'h0, 2'b10, 13'h0030, 0, 4'hF, 4'b0010, 13'h0030, 2'b00, 0));
    vecs.push_back(mk(2'b00, 13'h0000, 0, 4'h0, 2'b00, 13'h0000, 0, 4'h0, 4'b0000, 13'h0000, 2'b01, 32'h0BADF00D));
    vecs.push_back(mk(2'b10, 13'h0010, 0, 4'hF, 2'b01, 13'h0040, 32'h55, 4'hF, 4'b0110, 13'h0010, 2'b00, 0));
    vecs.push_back(mk(2'b00, 13'h0000, 0, 4'h0, 2'b01, 13'h0040, 32'h55, 4'hF, 4'b0011, 13'h0040, 2'b10, 32'hDEADBEEF));

`ifdef SOC_RAM_ARB_LOCK_EN
    m0_lock = 1'b0;
    m1_lock = 1'b0;
`endif
    reset_n = 1'b0;
    drive(2'b10, 13'h0010, 0, 4'hF, 2'b10, 13'h0020, 0, 4'hF);
    step();
    @(negedge clk);
    chk("rst m0_waitrequest", m0_waitrequest, 1);
    chk("rst m1_waitrequest", m1_waitrequest, 1);
    chk("rst ram_chipselect", ram_chipselect, 0);
    chk("rst ram_write", ram_write, 0);
    chk("rst ram_clken", ram_clken, 0);
    chk("rst readdatavalid", {m0_readdatavalid, m1_readdatavalid}, 0);
    step();
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].rw0, vecs[i].a0, vecs[i].wd0, vecs[i].be0,
            vecs[i].rw1, vecs[i].a1, vecs[i].wd1, vecs[i].be1);
      @(negedge clk);
      chk($sformatf("v%0d m0_waitrequest", i), m0_waitrequest, vecs[i].ex[3]);
      chk($sformatf("v%0d m1_waitrequest", i), m1_waitrequest, vecs[i].ex[2]);
      chk($sformatf("v%0d ram_chipselect", i), ram_chipselect, vecs[i].ex[1]);
      chk($sformatf("v%0d ram_write", i), ram_write, vecs[i].ex[0]);
      if (vecs[i].ex[1]) chk($sformatf("v%0d ram_address", i), ram_address, vecs[i].ea);
      chk($sformatf("v%0d m0_readdatavalid", i), m0_readdatavalid, vecs[i].erv[1]);
      chk($sformatf("v%0d m1_readdatavalid", i), m1_readdatavalid, vecs[i].erv[0]);
      if (vecs[i].erv[1]) chk($sformatf("v%0d m0_readdata", i), m0_readdata, vecs[i].erd);
      if (vecs[i].erv[0]) chk($sformatf("v%0d m1_readdata", i), m1_readdata, vecs[i].erd);
      step();
    end

    // Read accepted, then reset: the response is dropped and arbitration restarts at m0.
    drive(2'b10, 13'h0010, 0, 4'hF, 2'b00, 13'h0, 0, 4'h0);
    @(negedge clk);
    chk("pre-rst m0 accepted", m0_waitrequest, 0);
    step();
    reset_n = 1'b0;
    drive(2'b10, 13'h0010, 0, 4'hF, 2'b10, 13'h0020, 0, 4'hF);
    @(negedge clk);
    chk("mid-rst m0_readdatavalid", m0_readdatavalid, 0);
    chk("mid-rst waitrequests", {m0_waitrequest, m1_waitrequest}, 2'b11);
    chk("mid-rst ram_chipselect", ram_chipselect, 0);
    chk("mid-rst ram_clken", ram_clken, 0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("post-rst contention", {m0_waitrequest, m1_waitrequest}, 2'b01);
    chk("post-rst ram_address", ram_address, 13'h0010);
    chk("post-rst ram_clken", ram_clken, 1);
    step();

`ifdef SOC_RAM_ARB_LOCK_EN
    // m0 locks, then idles: m1 waits LOCK_MAX cycles, then the lock is forced off.
    do_reset();
    drive(2'b10, 13'h0010, 0, 4'hF, 2'b00, 13'h0, 0, 4'h0);
    m0_lock = 1'b1;
    @(negedge clk);
    chk("lk1 m0 granted", m0_waitrequest, 0);
    step();
    drive(2'b00, 13'h0, 0, 4'h0, 2'b10, 13'h0020, 0, 4'hF);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("lk1 m1 waits c%0d", c), m1_waitrequest, 1);
      chk($sformatf("lk1 lock_err c%0d", c), lock_err, 0);
      step();
    end
    @(negedge clk);
    chk("lk1 m1 granted", m1_waitrequest, 0);
    chk("lk1 lock_err", lock_err, 1);
    step();
    m0_lock = 1'b0;

    // m1 locked write then unlocked read; m0 waits through both.
    do_reset();
    drive(2'b00, 13'h0, 0, 4'h0, 2'b01, 13'h0040, 32'h77, 4'hF);
    m1_lock = 1'b1;
    @(negedge clk);
    chk("lk2 m1 write granted", m1_waitrequest, 0);
    step();
    drive(2'b10, 13'h0010, 0, 4'hF, 2'b10, 13'h0040, 0, 4'hF);
    m1_lock = 1'b0;
    @(negedge clk);
    chk("lk2 m1 read granted", m1_waitrequest, 0);
    chk("lk2 m0 waits", m0_waitrequest, 1);
    step();
    drive(2'b10, 13'h0010, 0, 4'hF, 2'b00, 13'h0, 0, 4'h0);
    @(negedge clk);
    chk("lk2 m0 granted", m0_waitrequest, 0);
    chk("lk2 m1 readdatavalid", m1_readdatavalid, 1);
    chk("lk2 m1 readdata", m1_readdata, 32'h77);
    chk("lk2 lock_err", lock_err, 0);
    step();
`endif

    idle();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
